segment_scan_reader: RTL

Receive side of the team's multiplexed seven-segment display bus. The block samples the active-low segment lines and active-low digit strobes produced by the display drivers and reconstructs the BCD value and decimal point shown on every digit. It sits beside the display drivers as a loop-back checker for self-test and as a front end for boards that snoop an external display. It performs the inverse mapping of the team's BCD-to-segment decoder, flags patterns that are not valid digits, and pulses once per complete display frame.

---
 rtl/segment_scan_reader_if.sv | 22 ++
 rtl/segment_scan_reader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/segment_scan_reader_if.sv
// Seven-segment scan bus: driver-side segment/strobe lines
// plus the reader's reconstructed per-digit results.
interface segment_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp_out;
  logic [NDIG-1:0]   bad;
  logic              frame_valid;

  modport master (
    output seg, an,
    input  digits, dp_out, bad, frame_valid
  );

  modport slave (
    input  seg, an,
    output digits, dp_out, bad, frame_valid
  );
endinterface

// File: rtl/segment_scan_reader.sv
// Recovers BCD digits from a multiplexed seven-segment bus.
// SEGREAD_ALT_GLYPH_EN: also accept alternate 6, 7 and 9 glyphs.
module segment_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic clk,
  input  logic rst,
  segment_scan_reader_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } state_t;

  localparam logic [3:0] STAB = 4'(STABLE);

  state_t            state, state_nxt;
  logic [NDIG-1:0]   s_an, p_an;
  logic [7:0]        s_seg, p_seg;
  logic [3:0]        cnt, cnt_nxt;
  logic [NDIG-1:0]   strobe;
  logic              legal, same, clear;
  logic              capture, frame_hit;
  logic [NDIG-1:0]   seen, seen_nxt;
  logic [3:0]        glyph;
  logic              glyph_bad;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp, bad;
  logic              frame;

  function automatic logic [4:0] decode(
    input logic [6:0] g
  );
    logic [4:0] r;
    r = 5'd0;
    case (g)
      7'b1000000: r[3:0] = 4'd0;
      7'b1111001: r[3:0] = 4'd1;
      7'b0100100: r[3:0] = 4'd2;
      7'b0110000: r[3:0] = 4'd3;
      7'b0011001: r[3:0] = 4'd4;
      7'b0010010: r[3:0] = 4'd5;
      7'b0000010: r[3:0] = 4'd6;
      7'b1111000: r[3:0] = 4'd7;
      7'b0000000: r[3:0] = 4'd8;
      7'b0010000: r[3:0] = 4'd9;
`ifdef SEGREAD_ALT_GLYPH_EN
      7'b0000011: r[3:0] = 4'd6;
      7'b1011000: r[3:0] = 4'd7;
      7'b0011000: r[3:0] = 4'd9;
`endif
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  assign strobe = ~s_an;
  assign legal  = (strobe != '0) &&
                  ((strobe & (strobe - NDIG'(1))) == '0);
  assign same   = (s_an == p_an) && (s_seg == p_seg);
  assign clear  = !(legal && same);

  assign {glyph_bad, glyph} = decode(s_seg[6:0]);

  always_comb begin
    cnt_nxt = 4'd0;
    if (!clear)
      cnt_nxt = (cnt == STAB) ? cnt : cnt + 4'd1;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      WAIT: begin
        if (legal) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (clear) begin
          state_nxt = legal ? SETTLE : WAIT;
        end else if (cnt_nxt == STAB) begin
          state_nxt = HELD;
          capture   = 1'b1;
        end
      end
      HELD: begin
        if (clear) state_nxt = legal ? SETTLE : WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  // A completing capture restarts the frame with an empty mask.
  assign seen_nxt  = seen | (capture ? strobe : '0);
  assign frame_hit = capture && (&seen_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_an   <= '1;
      p_an   <= '1;
      s_seg  <= '1;
      p_seg  <= '1;
      cnt    <= 4'd0;
      state  <= WAIT;
      seen   <= '0;
      digits <= '0;
      dp     <= '0;
      bad    <= '0;
      frame  <= 1'b0;
    end else begin
      s_an   <= bus.an;
      s_seg  <= bus.seg;
      p_an   <= s_an;
      p_seg  <= s_seg;
      cnt    <= cnt_nxt;
      state  <= state_nxt;
      frame  <= frame_hit;
      seen   <= frame_hit ? '0 : seen_nxt;
      if (capture) begin
        for (int i = 0; i < NDIG; i++) begin
          if (strobe[i]) begin
            digits[4*i +: 4] <= glyph;
            dp[i]            <= ~s_seg[7];
            bad[i]           <= glyph_bad;
          end
        end
      end
    end
  end

  assign bus.digits      = digits;
  assign bus.dp_out      = dp;
  assign bus.bad         = bad;
  assign bus.frame_valid = frame;

endmodule
